// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - erase / fill / erase-then-draw rectangle blitter with screen clipping
// One pixel per cycle, raster order, single output register stage toward the VGA write port.
module sprite_blitter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 4,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x_old,
  input  logic [Y_W-1:0]     y_old,
  input  logic [X_W-1:0]     x_new,
  input  logic [Y_W-1:0]     y_new,
  input  logic [COLOR_W-1:0] fg_color,
  output logic [X_W-1:0]     bg_x,
  output logic [Y_W-1:0]     bg_y,
  input  logic [COLOR_W-1:0] bg_color,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_color
);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_FLUSH, S_DONE} state_t;

  localparam logic [3:0] LAST_C = 4'(SPR_W - 1);
  localparam logic [3:0] LAST_R = 4'(SPR_H - 1);

  state_t               r_state;
  logic [3:0]           r_col;
  logic [3:0]           r_row;
  logic [1:0]           r_mode;
  logic [X_W-1:0]       r_xo;
  logic [Y_W-1:0]       r_yo;
  logic [X_W-1:0]       r_xn;
  logic [Y_W-1:0]       r_yn;
  logic [COLOR_W-1:0]   r_fg;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_plot;
  logic                 r_erase_q;
  logic [X_W-1:0]       r_vga_x;
  logic [Y_W-1:0]       r_vga_y;
  logic [COLOR_W-1:0]   r_color;

  logic                 w_erase;
  logic                 w_last;
  logic                 w_clip;
  logic [X_W:0]         w_px;
  logic [Y_W:0]         w_py;

  // Address carries one extra bit so origins near the screen edge clip instead of wrapping.
  always_comb begin
    w_erase = (r_state == S_ERASE);
    w_px    = (w_erase ? {1'b0, r_xo} : {1'b0, r_xn}) + (X_W+1)'(r_col);
    w_py    = (w_erase ? {1'b0, r_yo} : {1'b0, r_yn}) + (Y_W+1)'(r_row);
    w_clip  = (w_px >= (X_W+1)'(SCREEN_W)) || (w_py >= (Y_W+1)'(SCREEN_H));
    w_last  = (r_col == LAST_C) && (r_row == LAST_R);
  end

  assign bg_x      = w_erase ? w_px[X_W-1:0] : '0;
  assign bg_y      = w_erase ? w_py[Y_W-1:0] : '0;
  // Background data returns one cycle after its address, aligned with the registered pixel.
  assign vga_color = r_erase_q ? bg_color : r_color;
  assign busy      = r_busy;
  assign done      = r_done;
  assign plot      = r_plot;
  assign vga_x     = r_vga_x;
  assign vga_y     = r_vga_y;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= '0;
      r_xo      <= '0;
      r_yo      <= '0;
      r_xn      <= '0;
      r_yn      <= '0;
      r_fg      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_plot    <= 1'b0;
      r_erase_q <= 1'b0;
      r_vga_x   <= '0;
      r_vga_y   <= '0;
      r_color   <= '0;
    end else begin
      r_plot    <= 1'b0;
      r_done    <= 1'b0;
      r_erase_q <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_xo   <= x_old;
            r_yo   <= y_old;
            r_xn   <= x_new;
            r_yn   <= y_new;
            r_fg   <= fg_color;
            r_col  <= '0;
            r_row  <= '0;
            r_busy <= 1'b1;
            r_state <= (mode == 2'b01 || mode == 2'b10) ? S_ERASE : S_DRAW;
          end
        end
        S_ERASE, S_DRAW: begin
          r_plot    <= ~w_clip;
          r_vga_x   <= w_px[X_W-1:0];
          r_vga_y   <= w_py[Y_W-1:0];
          r_erase_q <= w_erase;
          r_color   <= r_fg;
          if (w_last) begin
            r_col <= '0;
            r_row <= '0;
            if (w_erase && r_mode == 2'b10) r_state <= S_DRAW;
            else                            r_state <= S_FLUSH;
          end else if (r_col == LAST_C) begin
            r_col <= '0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        S_FLUSH: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter (4x4 and 8x2 instances)
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       resetn, start_a, start_b;
  logic [1:0] mode;
  logic [8:0] x_old, x_new;
  logic [7:0] y_old, y_new;
  logic [2:0] fg_color;

  logic [8:0] bg_x_a, vga_x_a, bg_x_b, vga_x_b;
  logic [7:0] bg_y_a, vga_y_a, bg_y_b, vga_y_b;
  logic [2:0] bg_a, bg_b, vga_color_a, vga_color_b;
  logic       busy_a, done_a, plot_a, busy_b, done_b, plot_b;

  logic [19:0] q_a[$];
  logic [19:0] q_b[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_blitter dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .mode(mode),
    .x_old(x_old), .y_old(y_old), .x_new(x_new), .y_new(y_new), .fg_color(fg_color),
    .bg_x(bg_x_a), .bg_y(bg_y_a), .bg_color(bg_a),
    .busy(busy_a), .done(done_a), .plot(plot_a),
    .vga_x(vga_x_a), .vga_y(vga_y_a), .vga_color(vga_color_a)
  );

  sprite_blitter #(.SPR_W(8), .SPR_H(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .mode(mode),
    .x_old(x_old), .y_old(y_old), .x_new(x_new), .y_new(y_new), .fg_color(fg_color),
    .bg_x(bg_x_b), .bg_y(bg_y_b), .bg_color(bg_b),
    .busy(busy_b), .done(done_b), .plot(plot_b),
    .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_color(vga_color_b)
  );

  // Background memory model: colour = x[2:0], one-cycle read latency.
  always @(posedge clk) begin
    bg_a <= bg_x_a[2:0];
    bg_b <= bg_x_b[2:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (plot_a) begin
      if (q_a.size() == 0) chk("extra_plot_a", 1, 0);
      else chk("pixel_a", {12'd0, vga_x_a, vga_y_a, vga_color_a}, {12'd0, q_a.pop_front()});
    end
    if (plot_b) begin
      if (q_b.size() == 0) chk("extra_plot_b", 1, 0);
      else chk("pixel_b", {12'd0, vga_x_b, vga_y_b, vga_color_b}, {12'd0, q_b.pop_front()});
    end
  end

  function automatic void push(input bit sel, input int x, input int y, input logic [2:0] c);
    logic [19:0] e;
    if (x < 320 && y < 240) begin
      e = {9'(x), 8'(y), c};
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endfunction

  task automatic run(input bit sel, input logic [1:0] md, input int xo, input int yo,
                     input int xn, input int yn, input logic [2:0] fg,
                     input int exp_lat, input bit glitch, input int rst_at);
    int k, sw, sh, nd;
    bit hit_done;
    sw = sel ? 8 : 4;
    sh = sel ? 2 : 4;
    if (md == 2'b01 || md == 2'b10)
      for (int r = 0; r < sh; r++)
        for (int c = 0; c < sw; c++) push(sel, xo + c, yo + r, 3'((xo + c) % 8));
    if (md != 2'b01)
      for (int r = 0; r < sh; r++)
        for (int c = 0; c < sw; c++) push(sel, xn + c, yn + r, fg);
    mode = md; x_old = 9'(xo); y_old = 8'(yo); x_new = 9'(xn); y_new = 8'(yn); fg_color = fg;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    k = 1; hit_done = 1'b0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (k == 2) chk("busy_after_start", 32'(sel ? busy_b : busy_a), 1);
      if (rst_at != 0 && k == rst_at) begin
        resetn = 1'b0;
        @(negedge clk);
        chk("plot_after_reset", 32'(plot_a), 0);
        chk("busy_after_reset", 32'(busy_a), 0);
        resetn = 1'b1;
        q_a.delete(); q_b.delete();
        break;
      end
      if (sel ? done_b : done_a) begin hit_done = 1'b1; break; end
      if (glitch) begin
        start_a  = (k == 5 || k == 18);
        fg_color = ~fg;
        x_new    = 9'd0;
      end
    end
    start_a = 1'b0;
    if (rst_at == 0) begin
      chk("latency", 32'(k), 32'(exp_lat));
      chk("busy_in_done", 32'(sel ? busy_b : busy_a), 0);
      chk("done_seen", 32'(hit_done), 1);
    end
    nd = 0;
    repeat ((rst_at != 0) ? 25 : 4) begin
      @(negedge clk);
      if (sel ? done_b : done_a) nd++;
    end
    chk("extra_done", 32'(nd), 0);
    chk("queue_empty", 32'(sel ? q_b.size() : q_a.size()), 0);
  endtask

  initial begin
    resetn = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 2'b00;
    x_old = '0; y_old = '0; x_new = '0; y_new = '0; fg_color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_plot", 32'(plot_a), 0);
    chk("rst_vga", {12'd0, vga_x_a, vga_y_a, vga_color_a}, 0);
    chk("rst_bg", {15'd0, bg_x_a, bg_y_a}, 0);
    @(posedge clk); #1 resetn = 1'b1;

    run(0, 2'b00, 0, 0, 10, 20, 3'b100, 19, 0, 0);
    run(0, 2'b10, 0, 16, 1, 16, 3'b110, 35, 0, 0);
    run(0, 2'b00, 0, 0, 318, 238, 3'b011, 19, 0, 0);
    run(0, 2'b00, 0, 0, 40, 30, 3'b101, 19, 1, 0);
    run(0, 2'b00, 0, 0, 10, 20, 3'b010, 0, 0, 10);
    run(0, 2'b00, 0, 0, 10, 20, 3'b100, 19, 0, 0);
    run(1, 2'b01, 100, 50, 0, 0, 3'b111, 19, 0, 0);
    run(0, 2'b11, 0, 0, 50, 60, 3'b001, 19, 0, 0);
    run(0, 2'b01, 317, 237, 0, 0, 3'b000, 19, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
